dla_soft_reset_sequencer: RTL



---
 rtl/dla_reset_pkg.sv | 26 ++
 rtl/dla_reset_down_counter.sv | 37 +++
 rtl/dla_soft_reset_sequencer.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/dla_reset_pkg.sv
// Shared types and defaults for the coreDLA soft reset sequencer.
// Holds the sequencer state encoding and the counter-width helper.
package dla_reset_pkg;

    typedef enum logic [2:0] {
        ST_RUN,
        ST_DRAIN,
        ST_ASSERT,
        ST_RELEASE,
        ST_DONE
    } rst_state_e;

    localparam int DEFAULT_HOLD_CYCLES    = 16;
    localparam int DEFAULT_RELEASE_CYCLES = 8;
    localparam int DEFAULT_DRAIN_TIMEOUT  = 1024;

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Wide enough to hold the largest of the three phase lengths.
    function automatic int counter_width(input int hold, input int rel, input int drain);
        return $clog2(imax(imax(hold, rel), imax(drain, 1)) + 1);
    endfunction

endpackage

// File: rtl/dla_reset_down_counter.sv
// Loadable down-counter with a zero flag, shared by all timed sequencer phases.
// Load has priority over decrement; the count holds when neither is requested.
module dla_reset_down_counter #(
    parameter int               WIDTH       = 5,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_value;
        end else if (dec) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= RESET_VALUE;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/dla_soft_reset_sequencer.sv
// Produces the active-low reset for the coreDLA reset handler, merging the board
// reset with a CSR soft reset request (drain, hold low, release window, done).
module dla_soft_reset_sequencer
    import dla_reset_pkg::*;
#(
    parameter int HOLD_CYCLES    = DEFAULT_HOLD_CYCLES,
    parameter int RELEASE_CYCLES = DEFAULT_RELEASE_CYCLES,
    parameter int DRAIN_TIMEOUT  = DEFAULT_DRAIN_TIMEOUT
) (
    input  logic clk,
    input  logic i_resetn,
    input  logic i_sw_reset_req,
    input  logic i_idle,
    output logic o_resetn,
    output logic o_busy,
    output logic o_done,
    output logic o_drain_timeout
);

    localparam int CNT_W = counter_width(HOLD_CYCLES, RELEASE_CYCLES, DRAIN_TIMEOUT);

    localparam int HOLD_LOAD_I  = (HOLD_CYCLES > 0)    ? HOLD_CYCLES - 1    : 0;
    localparam int REL_LOAD_I   = (RELEASE_CYCLES > 0) ? RELEASE_CYCLES - 1 : 0;
    localparam int DRAIN_LOAD_I = (DRAIN_TIMEOUT > 0)  ? DRAIN_TIMEOUT - 1  : 0;

    localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_LOAD_I);
    localparam logic [CNT_W-1:0] REL_LOAD   = CNT_W'(REL_LOAD_I);
    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_LOAD_I);

    if (HOLD_CYCLES < 1) begin : g_bad_hold
        $fatal(1, "HOLD_CYCLES must be >= 1");
    end
    if (RELEASE_CYCLES < 0) begin : g_bad_release
        $fatal(1, "RELEASE_CYCLES must be >= 0");
    end
    if (DRAIN_TIMEOUT < 0) begin : g_bad_drain
        $fatal(1, "DRAIN_TIMEOUT must be >= 0");
    end

    rst_state_e state_q, state_d;
    logic       req_prev_q;
    (* dont_merge *) logic resetn_q;
    logic       resetn_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       drain_timeout_q, drain_timeout_d;

    logic             trig;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_load_value;
    logic             cnt_dec;
    logic             cnt_zero;

    assign trig = i_sw_reset_req & ~req_prev_q;

    dla_reset_down_counter #(
        .WIDTH       (CNT_W),
        .RESET_VALUE (HOLD_LOAD)
    ) u_counter (
        .clk        (clk),
        .rst_n      (i_resetn),
        .load       (cnt_load),
        .load_value (cnt_load_value),
        .dec        (cnt_dec),
        .zero       (cnt_zero)
    );

    always_comb begin
        state_d         = state_q;
        cnt_load        = 1'b0;
        cnt_load_value  = '0;
        cnt_dec         = 1'b0;
        drain_timeout_d = drain_timeout_q;

        case (state_q)
            ST_RUN: begin
                if (trig) begin
                    state_d         = ST_DRAIN;
                    drain_timeout_d = 1'b0;
                    cnt_load        = 1'b1;
                    cnt_load_value  = DRAIN_LOAD;
                end
            end
            ST_DRAIN: begin
                // Idle is checked first so it wins over a coincident timeout.
                if (i_idle) begin
                    state_d        = ST_ASSERT;
                    cnt_load       = 1'b1;
                    cnt_load_value = HOLD_LOAD;
                end else if (DRAIN_TIMEOUT != 0) begin
                    if (cnt_zero) begin
                        state_d         = ST_ASSERT;
                        drain_timeout_d = 1'b1;
                        cnt_load        = 1'b1;
                        cnt_load_value  = HOLD_LOAD;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
            end
            ST_ASSERT: begin
                if (cnt_zero) begin
                    if (RELEASE_CYCLES == 0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d        = ST_RELEASE;
                        cnt_load       = 1'b1;
                        cnt_load_value = REL_LOAD;
                    end
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_RELEASE: begin
                if (cnt_zero) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_ASSERT;
            end
        endcase

        // Outputs are registered from the next state so they change on the entering edge.
        resetn_d = (state_d != ST_ASSERT);
        busy_d   = (state_d != ST_RUN);
        done_d   = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge i_resetn) begin
        if (!i_resetn) begin
            state_q         <= ST_ASSERT;
            req_prev_q      <= 1'b1;
            resetn_q        <= 1'b0;
            busy_q          <= 1'b1;
            done_q          <= 1'b0;
            drain_timeout_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            req_prev_q      <= i_sw_reset_req;
            resetn_q        <= resetn_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            drain_timeout_q <= drain_timeout_d;
        end
    end

    assign o_resetn        = resetn_q;
    assign o_busy          = busy_q;
    assign o_done          = done_q;
    assign o_drain_timeout = drain_timeout_q;

endmodule
